regfile_scan_checker: RTL
=========================

// Module: regfile_scan_checker
// PURPOSE
//  Synthesizable successor to the simulation-only run-and-check harness.
//  Runs the processor for a programmable number of cycles, then freezes it and takes over regfile read port A.
//  Sweeps all registers and compares each against an expected-value memory, counting mismatches.
//  Optionally logs every architectural register write into a trace FIFO. Sits between processor and regfile in on-board test builds.
// PARAMETERS
//  DATA_W         32   register/data width
//  NUM_REGS       32   registers swept (index 0..NUM_REGS-1)
//  ADDR_W         5    register index width, >= clog2(NUM_REGS)
//  CYCLE_W        10   run-cycle counter width
//  DEFAULT_CYCLES 255  run length used when num_cycles==0
//  TRACE_DEPTH    16   trace FIFO entries, power of 2
// PORTS
//  clock         in  1        single clock, all state on posedge
//  reset         in  1        synchronous, active-high
//  start         in  1        1-cycle pulse: begin a run; ignored unless IDLE/DONE
//  num_cycles    in  CYCLE_W  run length, sampled on accepted start
//  cpu_run       out 1        processor clock-enable; 1 only in RUN
//  cpu_reset     out 1        processor reset = reset | (state==CPU_RST)
//  rwe,rd,rData  in  1/ADDR_W/DATA_W  processor regfile write port (snooped)
//  rs1_cpu       in  ADDR_W   processor read-A index
//  rs1_out       out ADDR_W   to regfile read-A: rs1_cpu, or scan index in SCAN
//  regA          in  DATA_W   regfile read-A data (combinational read)
//  exp_addr      out ADDR_W   expected-value memory address
//  exp_data      in  DATA_W   expected value, valid 1 cycle after exp_addr
//  busy,done,pass out 1       status; pass valid when done
//  error_count   out clog2(NUM_REGS+1)  mismatches, saturating
//  fail_valid    out 1        1-cycle pulse per mismatch; fail_reg/fail_actual/fail_expected valid with it
//  trace_valid/trace_ready  out/in 1  trace FIFO pop handshake; pop when both high
//  trace_cycle/trace_reg/trace_data out CYCLE_W/ADDR_W/DATA_W  head entry
//  trace_overflow out 1       sticky: write dropped because FIFO full; cleared on start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except rs1_out=rs1_cpu, cpu_reset=1; counters, FIFO, error_count cleared.
//  FSM: IDLE -start-> CPU_RST (1 cycle) -> RUN -> SCAN -> CMP_LAST -> DONE; DONE -start-> CPU_RST.
//  RUN: cycle counter 0..N-1, N = num_cycles?num_cycles:DEFAULT_CYCLES; leave after exactly N RUN cycles.
//  SCAN: index k=0..NUM_REGS-1, one per cycle; rs1_out=exp_addr=k; regA registered with k.
//   Compare in following cycle vs exp_data; scan costs NUM_REGS+1 cycles incl. CMP_LAST.
//  Mismatch: fail_valid pulse; error_count++ saturating at NUM_REGS. Reg 0 is compared like any other.
//  DONE: done=1, busy=0, pass=(error_count==0); results held until next accepted start or reset.
//  busy=1 in CPU_RST/RUN/SCAN/CMP_LAST; start while busy ignored. reset mid-run: immediate return to IDLE, FIFO flushed.
//  Trace push: in RUN when rwe && rd!=0, entry {cycle counter, rd, rData}.
//   Full and no pop this cycle -> drop, set trace_overflow. Full with simultaneous pop -> push accepted.
//   Empty -> trace_valid=0; pop on empty is a no-op. FIFO drains in any state.
// CONFIGURATION
//  REGCHK_TRACE_EN defined: trace FIFO and trace_* outputs implemented.
//  Undefined: no FIFO; trace_valid, trace_overflow, trace_* data tied 0; trace_ready ignored; check unaffected.
// STRUCTURE
//  Package regchk_pkg: state enum (IDLE,CPU_RST,RUN,SCAN,CMP_LAST,DONE); trace_entry_t struct {cycle,reg,data}.
//  Sub-module regchk_trace_fifo: ready/valid FIFO of trace_entry_t, TRACE_DEPTH, full/empty, same-cycle push+pop.
//   Instantiated only under REGCHK_TRACE_EN.
// TESTING
//  1 num_cycles=20, regfile model preloaded to match exp memory -> busy 1+20+33 cycles, done=1, pass=1, error_count=0.
//  2 exp[5]=7, reg5=9, exp[31]=1, reg31=0 -> two fail_valid pulses (reg5: 9 vs 7, reg31: 0 vs 1), error_count=2, pass=0.
//  3 num_cycles=0 -> RUN lasts exactly 255 cycles, cpu_run high 255 cycles.
//  4 TRACE_EN, depth 16, 20 writes, trace_ready=0 -> 16 entries, trace_overflow=1; rd=0 writes never logged.
//  5 Write at cycle 3 to r4 of 0xDEAD, trace_ready=1 -> entry {3,4,0xDEAD}; push+pop when full, no drop.
//  6 reset pulsed mid-SCAN -> next cycle IDLE, error_count=0, rs1_out=rs1_cpu; start mid-RUN ignored.

Source files
------------

// File: rtl/regchk_pkg.sv
// Shared state encoding and trace-entry layout for the register-file scan checker.
package regchk_pkg;
  localparam int TE_CYCLE_W = 10;
  localparam int TE_ADDR_W  = 5;
  localparam int TE_DATA_W  = 32;

  typedef enum logic [2:0] {IDLE, CPU_RST, RUN, SCAN, CMP_LAST, DONE} state_e;

  typedef struct packed {
    logic [TE_CYCLE_W-1:0] cycle;
    logic [TE_ADDR_W-1:0]  reg_idx;
    logic [TE_DATA_W-1:0]  data;
  } trace_entry_t;
endpackage

// File: rtl/regchk_trace_fifo.sv
// Ready/valid FIFO of trace entries; a push into a full FIFO is accepted when a pop happens the same cycle.
module regchk_trace_fifo
  import regchk_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  trace_entry_t push_data,
  output logic         full,
  input  logic         pop,
  output logic         valid,
  output trace_entry_t head
);
  trace_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign valid   = (cnt_q != '0);
  assign pop_ok  = pop && valid;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop_ok && !push_ok) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q] <= push_data;
  end
endmodule

// File: rtl/regfile_scan_checker.sv
// Runs the CPU for N cycles, freezes it, then sweeps regfile read port A against an expected-value memory.
// Defining REGCHK_TRACE_EN adds a FIFO logging every architectural register write made during RUN.
module regfile_scan_checker
  import regchk_pkg::*;
#(
  parameter int DATA_W         = TE_DATA_W,
  parameter int NUM_REGS       = 32,
  parameter int ADDR_W         = TE_ADDR_W,
  parameter int CYCLE_W        = TE_CYCLE_W,
  parameter int DEFAULT_CYCLES = 255,
  parameter int TRACE_DEPTH    = 16,
  localparam int ERR_W         = $clog2(NUM_REGS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CYCLE_W-1:0] num_cycles,
  output logic               cpu_run,
  output logic               cpu_reset,
  input  logic               rwe,
  input  logic [ADDR_W-1:0]  rd,
  input  logic [DATA_W-1:0]  rData,
  input  logic [ADDR_W-1:0]  rs1_cpu,
  output logic [ADDR_W-1:0]  rs1_out,
  input  logic [DATA_W-1:0]  regA,
  output logic [ADDR_W-1:0]  exp_addr,
  input  logic [DATA_W-1:0]  exp_data,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   error_count,
  output logic               fail_valid,
  output logic [ADDR_W-1:0]  fail_reg,
  output logic [DATA_W-1:0]  fail_actual,
  output logic [DATA_W-1:0]  fail_expected,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [CYCLE_W-1:0] trace_cycle,
  output logic [ADDR_W-1:0]  trace_reg,
  output logic [DATA_W-1:0]  trace_data,
  output logic               trace_overflow
);
  state_e             state_q, state_d;
  logic [CYCLE_W-1:0] run_len_q, run_len_d, cyc_q, cyc_d;
  logic [ADDR_W-1:0]  idx_q, idx_d, cap_idx_q, cap_idx_d;
  logic [DATA_W-1:0]  cap_q, cap_d;
  logic               cmp_vld_q, cmp_vld_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fail_valid_q, fail_valid_d;
  logic [ADDR_W-1:0]  fail_reg_q, fail_reg_d;
  logic [DATA_W-1:0]  fail_act_q, fail_act_d, fail_exp_q, fail_exp_d;
  logic               start_acc, mismatch, in_scan;

  assign start_acc = start && (state_q == IDLE || state_q == DONE);
  assign in_scan   = (state_q == SCAN);
  // exp_data arrives one cycle after its address, so the sampled regA is held a cycle to line up.
  assign mismatch  = cmp_vld_q && (cap_q != exp_data);

  always_comb begin
    state_d      = state_q;
    run_len_d    = run_len_q;
    cyc_d        = cyc_q;
    idx_d        = idx_q;
    cap_d        = cap_q;
    cap_idx_d    = cap_idx_q;
    cmp_vld_d    = 1'b0;
    err_d        = err_q;
    fail_valid_d = mismatch;
    fail_reg_d   = fail_reg_q;
    fail_act_d   = fail_act_q;
    fail_exp_d   = fail_exp_q;
    if (mismatch) begin
      fail_reg_d = cap_idx_q;
      fail_act_d = cap_q;
      fail_exp_d = exp_data;
      if (err_q != ERR_W'(NUM_REGS)) err_d = err_q + ERR_W'(1);
    end
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d   = CPU_RST;
        run_len_d = (num_cycles != '0) ? num_cycles : CYCLE_W'(DEFAULT_CYCLES);
        cyc_d     = '0;
        err_d     = '0;
      end
      CPU_RST: begin
        state_d = RUN;
        cyc_d   = '0;
      end
      RUN: begin
        cyc_d = cyc_q + CYCLE_W'(1);
        if (cyc_q == run_len_q - CYCLE_W'(1)) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        cap_d     = regA;
        cap_idx_d = idx_q;
        cmp_vld_d = 1'b1;
        idx_d     = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(NUM_REGS - 1)) state_d = CMP_LAST;
      end
      CMP_LAST: state_d = DONE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      run_len_q    <= '0;
      cyc_q        <= '0;
      idx_q        <= '0;
      cap_q        <= '0;
      cap_idx_q    <= '0;
      cmp_vld_q    <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_reg_q   <= '0;
      fail_act_q   <= '0;
      fail_exp_q   <= '0;
    end else begin
      state_q      <= state_d;
      run_len_q    <= run_len_d;
      cyc_q        <= cyc_d;
      idx_q        <= idx_d;
      cap_q        <= cap_d;
      cap_idx_q    <= cap_idx_d;
      cmp_vld_q    <= cmp_vld_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_reg_q   <= fail_reg_d;
      fail_act_q   <= fail_act_d;
      fail_exp_q   <= fail_exp_d;
    end
  end

  assign cpu_run       = (state_q == RUN);
  assign cpu_reset     = reset | (state_q == CPU_RST);
  assign rs1_out       = in_scan ? idx_q : rs1_cpu;
  assign exp_addr      = in_scan ? idx_q : '0;
  assign busy          = (state_q == CPU_RST) || (state_q == RUN) || in_scan || (state_q == CMP_LAST);
  assign done          = (state_q == DONE);
  assign pass          = done && (err_q == '0);
  assign error_count   = err_q;
  assign fail_valid    = fail_valid_q;
  assign fail_reg      = fail_reg_q;
  assign fail_actual   = fail_act_q;
  assign fail_expected = fail_exp_q;

`ifdef REGCHK_TRACE_EN
  trace_entry_t push_entry, head;
  logic         push, fifo_full, ovf_q, ovf_d;

  assign push = cpu_run && rwe && (rd != '0);

  always_comb begin
    push_entry         = '0;
    push_entry.cycle   = cyc_q;
    push_entry.reg_idx = rd;
    push_entry.data    = rData;
  end

  regchk_trace_fifo #(.DEPTH(TRACE_DEPTH)) u_trace_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .full      (fifo_full),
    .pop       (trace_ready),
    .valid     (trace_valid),
    .head      (head)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (start_acc)                                ovf_d = 1'b0;
    else if (push && fifo_full && !trace_ready)   ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign trace_overflow = ovf_q;
  assign trace_cycle    = head.cycle;
  assign trace_reg      = head.reg_idx;
  assign trace_data     = head.data;
`else
  logic unused_trace;
  assign unused_trace   = ^{trace_ready, rwe, rd, rData, start_acc, TRACE_DEPTH[0]};
  assign trace_valid    = 1'b0;
  assign trace_overflow = 1'b0;
  assign trace_cycle    = '0;
  assign trace_reg      = '0;
  assign trace_data     = '0;
`endif
endmodule
